// File: rtl/imem_resp.sv
// imem_resp: instruction-side memory responder with a word RAM, byte-strobed
// writes, fences and a fixed number of wait states before each response.

package imem_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module imem_resp
    import imem_pkg::*;
#(
    parameter int          mem_depth   = 10,
    parameter logic [31:0] base_addr   = 32'h0,
    parameter int          wait_cycles = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    output logic        err
);

    localparam int unsigned WORDS    = 2 ** mem_depth;
    localparam logic [32:0] SPAN     = 33'(4) << mem_depth;
    localparam logic [3:0]  WAIT_CNT = 4'(wait_cycles);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;
    logic [31:0]            r_rdata;
    logic [31:0]            w_rdata_nxt;
    logic                   r_err;

    // Captured request, reduced to what the response needs.
    logic                   r_rd;
    logic [mem_depth-1:0]   r_idx;

    logic [31:0]            r_mem [WORDS] = '{default: '0};

    logic [31:0]            w_offset;
    logic                   w_in_range;
    logic [mem_depth-1:0]   w_idx;
    logic                   w_capture;
    logic                   w_is_read;
    logic                   w_is_write;
    logic                   w_src_rd;
    logic [mem_depth-1:0]   w_src_idx;
    logic                   w_unused;

    assign w_offset   = imem_in.mem_addr - base_addr;
    assign w_in_range = ({1'b0, w_offset} < SPAN);
    assign w_idx      = w_offset[mem_depth+1:2];
    assign w_capture  = (r_state == S_IDLE) && imem_in.mem_valid;
    assign w_is_read  = !imem_in.mem_fence && w_in_range && (imem_in.mem_wstrb == 4'b0000);
    assign w_is_write = !imem_in.mem_fence && w_in_range && (imem_in.mem_wstrb != 4'b0000);
    // mem_instr is accepted but has no effect; low address bits select nothing.
    assign w_unused   = ^{imem_in.mem_instr, w_offset[1:0]};

    // With zero wait states the response is formed straight from the live
    // request; otherwise from what was captured when leaving IDLE.
    assign w_src_rd   = (r_state == S_IDLE) ? w_is_read : r_rd;
    assign w_src_idx  = (r_state == S_IDLE) ? w_idx     : r_idx;

    // Next-state, wait counter and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = 1'b0;
        w_rdata_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (imem_in.mem_valid) begin
                    w_cnt_nxt   = WAIT_CNT;
                    w_state_nxt = (WAIT_CNT != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_state_nxt == S_RESP) begin
            w_ready_nxt = 1'b1;
            if (w_src_rd) begin
                w_rdata_nxt = r_mem[w_src_idx];
            end
        end
    end

    // State register, registered outputs and sticky range error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_rdata <= w_rdata_nxt;
            // A fence touches no memory, so its address is not range-checked.
            if (w_capture && !imem_in.mem_fence && !w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    // Capture the read decision and word index when a request is accepted.
    always_ff @(posedge clock) begin
        if (w_capture && !reset) begin
            r_rd  <= w_is_read;
            r_idx <= w_idx;
        end
    end

    // Byte-strobed RAM write at the capture edge; reset leaves RAM contents alone.
    always_ff @(posedge clock) begin
        if (w_capture && !reset && w_is_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (imem_in.mem_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= imem_in.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign imem_out.mem_ready = r_ready;
    assign imem_out.mem_rdata = r_rdata;
    assign err                = r_err;

endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: three instances with 0, 1 and 3 wait states, directed
// scenarios plus randomized traffic checked against a behavioural memory model.

module tb_imem_resp;
    import imem_pkg::*;

    localparam int          MD   = 4;
    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    mem_in_type  din  [3];
    mem_out_type dout [3];
    logic        derr [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] m_ram [3][NW];
    logic        m_err [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_resp #(
            .mem_depth  (MD),
            .base_addr  (BASE),
            .wait_cycles((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clock   (clk),
            .reset   (rst),
            .imem_in (din[g]),
            .imem_out(dout[g]),
            .err     (derr[g])
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: returns the response data a request must produce.
    task automatic model_apply(input int k, input bit fence, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               output logic [31:0] exp);
        logic [31:0] off;
        int w;
        off = addr - BASE;
        exp = 32'h0;
        if (fence) begin
            exp = 32'h0;
        end else if (off >= 32'(4 * NW)) begin
            m_err[k] = 1'b1;
        end else begin
            w = int'(off >> 2);
            if (wstrb != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) m_ram[k][w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp = m_ram[k][w];
            end
        end
    endtask

    task automatic drive(input int k, input bit fence, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        din[k].mem_valid = 1'b1;
        din[k].mem_fence = fence;
        din[k].mem_instr = 1'($urandom_range(0, 1));
        din[k].mem_addr  = addr;
        din[k].mem_wdata = wdata;
        din[k].mem_wstrb = wstrb;
    endtask

    // One full handshake; returns data and the cycle number of the ready pulse.
    task automatic access(input int k, input bit fence, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] got, output int rc);
        logic [31:0] exp;
        int lat;
        @(negedge clk);
        drive(k, fence, addr, wdata, wstrb);
        model_apply(k, fence, addr, wdata, wstrb, exp);
        lat = -1;
        got = 32'h0;
        rc  = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (dout[k].mem_ready) begin
                lat = n;
                got = dout[k].mem_rdata;
                rc  = cyc;
                break;
            end
            chk("rdata_zero_when_not_ready", dout[k].mem_rdata, 32'h0);
        end
        chk("latency", 32'(lat), 32'(1 + wait_of(k)));
        chk("rdata", got, exp);
        chk("err", 32'(derr[k]), 32'(m_err[k]));
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        din[k].mem_valid = 1'b0;
        chk("ready_one_cycle", 32'(dout[k].mem_ready), 32'h0);
        chk("rdata_after_resp", dout[k].mem_rdata, 32'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) din[k].mem_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("reset_ready", 32'(dout[k].mem_ready), 32'h0);
                chk("reset_rdata", dout[k].mem_rdata, 32'h0);
                chk("reset_err", 32'(derr[k]), 32'h0);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) m_err[k] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] v;
        int rc;
        int prev;
        int k;
        int nb;
        int op;
        logic [31:0] addr;
        logic [3:0]  strb;

        for (int i = 0; i < 3; i++) begin
            din[i]   = '0;
            m_err[i] = 1'b0;
            for (int j = 0; j < NW; j++) m_ram[i][j] = 32'h0;
        end

        // Reset state of every instance.
        do_reset(3);

        // Zero-initialised RAM reads back as zero.
        access(1, 1'b0, BASE + 32'd20, 32'h0, 4'b0000, got, rc);
        chk("ram_zero_init", got, 32'h0);
        idle(1);

        // Single wait state read of word 3.
        access(1, 1'b0, BASE + 32'd12, 32'hDEAD_BEEF, 4'b1111, got, rc);
        idle(1);
        access(1, 1'b0, BASE + 32'd12, 32'h0, 4'b0000, got, rc);
        chk("read_word3", got, 32'hDEAD_BEEF);
        idle(1);

        // Partial byte write merges into the old word.
        access(1, 1'b0, BASE + 32'd8, 32'hAABB_CCDD, 4'b1111, got, rc);
        idle(1);
        access(1, 1'b0, BASE + 32'd9, 32'h1122_3344, 4'b0101, got, rc);
        chk("write_resp_zero", got, 32'h0);
        idle(1);
        access(1, 1'b0, BASE + 32'd8, 32'h0, 4'b0000, got, rc);
        chk("byte_merge", got, 32'hAA22_CC44);
        idle(1);

        // Line fill with zero wait states: ready every second cycle.
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b0, BASE + 32'(4 * i), $urandom, 4'b1111, got, rc);
            idle(0);
        end
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b0, BASE + 32'(4 * i), 32'h0, 4'b0000, got, rc);
            if (i > 0) chk("fill_spacing", 32'(rc - prev), 32'd2);
            prev = rc;
        end
        idle(0);

        // Fence: zero data, no RAM change, no error.
        access(1, 1'b1, BASE + 32'd8, 32'hFFFF_FFFF, 4'b1111, got, rc);
        chk("fence_rdata", got, 32'h0);
        idle(1);
        access(1, 1'b0, BASE + 32'd8, 32'h0, 4'b0000, got, rc);
        chk("fence_ram_kept", got, 32'hAA22_CC44);
        idle(1);

        // Out-of-range read just past the window, and write just below it.
        access(1, 1'b0, BASE + 32'(4 * NW), 32'h0, 4'b0000, got, rc);
        chk("oor_err_set", 32'(derr[1]), 32'h1);
        idle(1);
        access(1, 1'b0, BASE - 32'd4, 32'h5555_AAAA, 4'b1111, got, rc);
        idle(1);
        access(1, 1'b0, BASE + 32'(4 * (NW - 1)), 32'h0, 4'b0000, got, rc);
        access(1, 1'b0, BASE, 32'h0, 4'b0000, got, rc);
        chk("err_sticky", 32'(derr[1]), 32'h1);
        idle(1);

        // Randomized traffic, short back-to-back bursts per instance.
        for (int i = 0; i < 120; i++) begin
            k  = $urandom_range(0, 2);
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                op = $urandom_range(0, 9);
                if (op == 0) begin
                    addr = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * NW) + 32'($urandom_range(0, 80))
                                                       : BASE - 32'(4 * $urandom_range(1, 8));
                end else begin
                    addr = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
                end
                strb = (op < 5) ? 4'b0000 : 4'($urandom_range(1, 15));
                access(k, (op == 9) && (addr - BASE < 32'(4 * NW)), addr, $urandom, strb, got, rc);
            end
            idle(k);
        end

        // Reset clears the sticky error.
        do_reset(2);

        // Reset during WAIT discards the response of a captured read.
        v = $urandom;
        access(2, 1'b0, BASE + 32'd20, v, 4'b1111, got, rc);
        idle(2);
        @(negedge clk);
        drive(2, 1'b0, BASE + 32'd20, 32'h0, 4'b0000);
        @(negedge clk);
        chk("wait_no_ready", 32'(dout[2].mem_ready), 32'h0);
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ready_after_reset", 32'(dout[2].mem_ready), 32'h0);
            chk("no_rdata_after_reset", dout[2].mem_rdata, 32'h0);
        end

        // A write captured before reset stays committed.
        @(negedge clk);
        v = $urandom;
        drive(2, 1'b0, BASE + 32'd24, v, 4'b1111);
        model_apply(2, 1'b0, BASE + 32'd24, v, 4'b1111, got);
        @(negedge clk);
        do_reset(1);
        access(2, 1'b0, BASE + 32'd24, 32'h0, 4'b0000, got, rc);
        chk("write_survives_reset", got, v);
        idle(2);
        access(2, 1'b0, BASE + 32'd20, 32'h0, 4'b0000, got, rc);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
